// File: rtl/sha256_mc_ctrl.sv
// rtl/sha256_mc_ctrl.sv - SHA-256 message-compression sequencer
//
// Streams the 64 schedule words into MC, one compression round per accepted
// word. It then runs MC's readout phase, buffers H0..H7 and streams them out.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   start, busy, done             block control / status (done = 1-cycle pulse)
//   w_data, w_valid, w_ready      schedule word input stream
//   mc_fsm_out, mc_count_out,     drive MC FSM_core_in / core_count_in / data_in
//   mc_data_out
//   mc_data_in                    MC data_out (readout words)
//   hash_data, hash_valid,        hash word output stream, H0 first,
//   hash_ready, hash_last         hash_last marks H7
module sha256_mc_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  w_valid,
    output logic                  w_ready,
    output logic [2:0]            mc_fsm_out,
    output logic [6:0]            mc_count_out,
    output logic [DATA_WIDTH-1:0] mc_data_out,
    input  logic [DATA_WIDTH-1:0] mc_data_in,
    output logic [DATA_WIDTH-1:0] hash_data,
    output logic                  hash_valid,
    input  logic                  hash_ready,
    output logic                  hash_last
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COMP,
        S_SETUP,
        S_READ,
        S_OUT
    } state_t;

    localparam logic [2:0] MC_HOLD     = 3'b000;
    localparam logic [2:0] MC_COMPRESS = 3'b011;
    localparam logic [2:0] MC_READOUT  = 3'b100;

    // READ runs for rd_q = 0 .. RD_LAST; word i is captured when rd_q = i + RD_SKEW.
    localparam logic [3:0] RD_SKEW = 4'(RD_LAT - 1);
    localparam logic [3:0] RD_LAST = 4'(RD_LAT + 6);

    state_t                  state_q, state_d;
    logic [6:0]              rnd_q, rnd_d;
    logic [2:0]              idx_q, idx_d;
    logic [3:0]              rd_q, rd_d;
    logic [DATA_WIDTH-1:0]   hbuf_q [8];
    logic [DATA_WIDTH-1:0]   hbuf_d [8];

    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    w_ready_q, w_ready_d;
    logic [2:0]              mc_fsm_q, mc_fsm_d;
    logic [6:0]              mc_count_q, mc_count_d;
    logic [DATA_WIDTH-1:0]   mc_data_q, mc_data_d;
    logic [DATA_WIDTH-1:0]   hash_data_q, hash_data_d;
    logic                    hash_valid_q, hash_valid_d;
    logic                    hash_last_q, hash_last_d;

    logic                    w_acc;
    logic                    h_acc;
    logic [4:0]              cap_diff;
    logic                    cap_en;
    logic [2:0]              nxt_idx;

    assign w_acc   = w_valid & w_ready_q;
    assign h_acc   = hash_valid_q & hash_ready;
    assign nxt_idx = idx_q + 3'd1;

    // Negative difference means the first readout word has not reached us yet.
    assign cap_diff = {1'b0, rd_q} - {1'b0, RD_SKEW};
    assign cap_en   = ~cap_diff[4] & ~cap_diff[3];

    always_comb begin
        state_d      = state_q;
        rnd_d        = rnd_q;
        idx_d        = idx_q;
        rd_d         = rd_q;
        hbuf_d       = hbuf_q;
        done_d       = 1'b0;
        mc_fsm_d     = mc_fsm_q;
        mc_count_d   = mc_count_q;
        mc_data_d    = mc_data_q;
        hash_data_d  = hash_data_q;
        hash_valid_d = hash_valid_q;
        hash_last_d  = hash_last_q;

        case (state_q)
            S_IDLE: begin
                mc_fsm_d   = MC_HOLD;
                mc_count_d = 7'd0;
                mc_data_d  = '0;
                if (start) begin
                    state_d = S_COMP;
                    rnd_d   = 7'd0;
                end
            end
            S_COMP: begin
                if (w_acc) begin
                    mc_fsm_d   = MC_COMPRESS;
                    mc_count_d = rnd_q;
                    mc_data_d  = w_data;
                    if (rnd_q == 7'd63) begin
                        state_d = S_SETUP;
                    end else begin
                        rnd_d = rnd_q + 7'd1;
                    end
                end else begin
                    // Stall: MC holds its working variables, count/data unchanged.
                    mc_fsm_d = MC_HOLD;
                end
            end
            S_SETUP: begin
                mc_fsm_d   = MC_READOUT;
                mc_count_d = 7'd0;
                rd_d       = 4'd0;
                state_d    = S_READ;
            end
            S_READ: begin
                mc_fsm_d   = MC_READOUT;
                // Count saturates at 7 so MC keeps producing H7 while the
                // pipeline of earlier words drains.
                mc_count_d = (rd_q < 4'd7) ? 7'(rd_q + 4'd1) : 7'd7;
                if (cap_en) begin
                    hbuf_d[cap_diff[2:0]] = mc_data_in;
                end
                if (rd_q == RD_LAST) begin
                    state_d      = S_OUT;
                    mc_fsm_d     = MC_HOLD;
                    mc_count_d   = 7'd0;
                    idx_d        = 3'd0;
                    hash_valid_d = 1'b1;
                    hash_data_d  = hbuf_q[0];
                    hash_last_d  = 1'b0;
                end else begin
                    rd_d = rd_q + 4'd1;
                end
            end
            S_OUT: begin
                if (h_acc) begin
                    if (idx_q == 3'd7) begin
                        state_d      = S_IDLE;
                        hash_valid_d = 1'b0;
                        hash_last_d  = 1'b0;
                        hash_data_d  = '0;
                        done_d       = 1'b1;
                    end else begin
                        idx_d       = nxt_idx;
                        hash_data_d = hbuf_q[nxt_idx];
                        hash_last_d = (nxt_idx == 3'd7);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d    = (state_d != S_IDLE);
        w_ready_d = (state_d == S_COMP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rnd_q        <= 7'd0;
            idx_q        <= 3'd0;
            rd_q         <= 4'd0;
            for (int i = 0; i < 8; i++) begin
                hbuf_q[i] <= '0;
            end
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            w_ready_q    <= 1'b0;
            mc_fsm_q     <= 3'b000;
            mc_count_q   <= 7'd0;
            mc_data_q    <= '0;
            hash_data_q  <= '0;
            hash_valid_q <= 1'b0;
            hash_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rnd_q        <= rnd_d;
            idx_q        <= idx_d;
            rd_q         <= rd_d;
            hbuf_q       <= hbuf_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            w_ready_q    <= w_ready_d;
            mc_fsm_q     <= mc_fsm_d;
            mc_count_q   <= mc_count_d;
            mc_data_q    <= mc_data_d;
            hash_data_q  <= hash_data_d;
            hash_valid_q <= hash_valid_d;
            hash_last_q  <= hash_last_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign w_ready      = w_ready_q;
    assign mc_fsm_out   = mc_fsm_q;
    assign mc_count_out = mc_count_q;
    assign mc_data_out  = mc_data_q;
    assign hash_data    = hash_data_q;
    assign hash_valid   = hash_valid_q;
    assign hash_last    = hash_last_q;

endmodule

// File: tb/tb_sha256_mc_ctrl.sv
// tb/tb_sha256_mc_ctrl.sv - directed bench for sha256_mc_ctrl with behavioural MC models
module tb_sha256_mc_ctrl;

    typedef logic [7:0][31:0] st_t;

    localparam logic [31:0] K_TAB [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [31:0] IV_TAB [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [31:0] EXP_H [0:7] = '{
        32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
        32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad
    };

    logic        clk;
    logic        rst;
    logic        sel;
    logic        start;
    logic        w_valid;
    logic        hash_ready;
    logic [31:0] w_data;
    logic [31:0] w_tab [0:63];

    int n_chk = 0;
    int n_err = 0;

    logic        busy1, done1, w_ready1, hash_valid1, hash_last1;
    logic [2:0]  mc_fsm1;
    logic [6:0]  mc_count1;
    logic [31:0] mc_data1, mc_din1, hash_data1;
    logic        busy3, done3, w_ready3, hash_valid3, hash_last3;
    logic [2:0]  mc_fsm3;
    logic [6:0]  mc_count3;
    logic [31:0] mc_data3, mc_din3, hash_data3;

    logic        busy_o, done_o, w_ready_o, hash_valid_o, hash_last_o;
    logic [2:0]  mc_fsm_o;
    logic [6:0]  mc_count_o;
    logic [31:0] mc_data_o, hash_data_o;

    sha256_mc_ctrl #(.DATA_WIDTH(32), .RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start & ~sel), .busy(busy1), .done(done1),
        .w_data(w_data), .w_valid(w_valid & ~sel), .w_ready(w_ready1),
        .mc_fsm_out(mc_fsm1), .mc_count_out(mc_count1), .mc_data_out(mc_data1),
        .mc_data_in(mc_din1), .hash_data(hash_data1), .hash_valid(hash_valid1),
        .hash_ready(hash_ready & ~sel), .hash_last(hash_last1)
    );

    sha256_mc_ctrl #(.DATA_WIDTH(32), .RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .start(start & sel), .busy(busy3), .done(done3),
        .w_data(w_data), .w_valid(w_valid & sel), .w_ready(w_ready3),
        .mc_fsm_out(mc_fsm3), .mc_count_out(mc_count3), .mc_data_out(mc_data3),
        .mc_data_in(mc_din3), .hash_data(hash_data3), .hash_valid(hash_valid3),
        .hash_ready(hash_ready & sel), .hash_last(hash_last3)
    );

    assign busy_o       = sel ? busy3       : busy1;
    assign done_o       = sel ? done3       : done1;
    assign w_ready_o    = sel ? w_ready3    : w_ready1;
    assign mc_fsm_o     = sel ? mc_fsm3     : mc_fsm1;
    assign mc_count_o   = sel ? mc_count3   : mc_count1;
    assign mc_data_o    = sel ? mc_data3    : mc_data1;
    assign hash_data_o  = sel ? hash_data3  : hash_data1;
    assign hash_valid_o = sel ? hash_valid3 : hash_valid1;
    assign hash_last_o  = sel ? hash_last3  : hash_last1;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic st_t iv_st();
        st_t s;
        for (int i = 0; i < 8; i++) s[i] = IV_TAB[i];
        return s;
    endfunction

    function automatic st_t sha_round(input st_t s, input logic [31:0] k, input logic [31:0] w);
        logic [31:0] t1, t2;
        st_t n;
        t1 = s[7] + (rotr(s[4], 6) ^ rotr(s[4], 11) ^ rotr(s[4], 25))
             + ((s[4] & s[5]) ^ (~s[4] & s[6])) + k + w;
        t2 = (rotr(s[0], 2) ^ rotr(s[0], 13) ^ rotr(s[0], 22))
             + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
        n[0] = t1 + t2; n[1] = s[0]; n[2] = s[1]; n[3] = s[2];
        n[4] = s[3] + t1; n[5] = s[4]; n[6] = s[5]; n[7] = s[6];
        return n;
    endfunction

    function automatic logic [31:0] st_word(input st_t s, input logic [2:0] i);
        return IV_TAB[i] + s[i];
    endfunction

    // MC models: round 0 restarts from the IV; readout with latency 1 and 3.
    st_t        st1, st3;
    logic [2:0] f3_h1, f3_h2;
    logic [6:0] c3_h1, c3_h2;

    always @(posedge clk) begin
        if (mc_fsm1 == 3'b011)
            st1 <= sha_round((mc_count1 == 7'd0) ? iv_st() : st1, K_TAB[mc_count1[5:0]], mc_data1);
        if (mc_fsm3 == 3'b011)
            st3 <= sha_round((mc_count3 == 7'd0) ? iv_st() : st3, K_TAB[mc_count3[5:0]], mc_data3);
        f3_h1 <= mc_fsm3;
        f3_h2 <= f3_h1;
        c3_h1 <= mc_count3;
        c3_h2 <= c3_h1;
    end

    assign mc_din1 = (mc_fsm1 == 3'b100) ? st_word(st1, mc_count1[2:0]) : 32'h0;
    assign mc_din3 = (f3_h2 == 3'b100) ? st_word(st3, c3_h2[2:0]) : 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_check(input string tn, input int n);
        int act = 0;
        for (int i = 0; i < n; i++) begin
            if (hash_valid_o || done_o || busy_o) act++;
            step();
        end
        chk({tn, ".idle_quiet"}, act, 0);
    endtask

    // One block compression; returns in the cycle done is seen (or after reset injection).
    task automatic run_block(input string tn, input int stall_at, input int bp_len,
                             input int poke_at, input int rst_at);
        int          wi = 0, stall_left = 0, bp_left = 0, n_hs = 0, n_c = 0;
        int          n_read = 0, n_c7 = 0, n_stall = 0, n_bp = 0;
        int          first_hv = -1, hs7_cyc = -1, done_cyc = -1;
        int          lat;
        bit          stall_used = 0, bp_used = 0, poke_used = 0;
        bit          seq_ok = 1, stall_cnt_ok = 1, bp_hold_ok = 1, busy_ok = 1;
        bit          accept;
        logic [31:0] got [8];
        logic [7:0]  last_pat = 8'h0;

        lat = sel ? 3 : 1;
        for (int i = 0; i < 8; i++) got[i] = 32'h0;
        start = 1'b1; w_valid = 1'b0; hash_ready = 1'b1;
        step();
        start = 1'b0;
        chk({tn, ".start_lat"}, {done_o, w_ready_o, busy_o}, 3'b011);

        for (int cyc = 0; cyc < 400; cyc++) begin
            if (mc_fsm_o == 3'b011) begin
                if (n_c > 63 || mc_count_o != 7'(n_c) || mc_data_o != w_tab[n_c[5:0]]) seq_ok = 0;
                n_c++;
            end
            if (mc_fsm_o == 3'b000 && n_c > 0 && n_c < 64) begin
                n_stall++;
                if (mc_count_o != 7'(n_c - 1)) stall_cnt_ok = 0;
            end
            if (mc_fsm_o == 3'b100) begin
                n_read++;
                if (mc_count_o == 7'd7) n_c7++;
            end
            if (!done_o && !busy_o) busy_ok = 0;
            if (hash_valid_o && first_hv < 0) first_hv = cyc;
            if (done_o) begin
                done_cyc = cyc;
                break;
            end

            if (rst_at >= 0 && wi == rst_at) begin
                #3 rst = 1'b1;
                #1;
                chk({tn, ".rst_ctrl"}, {busy_o, done_o, w_ready_o, hash_valid_o, hash_last_o,
                                        mc_fsm_o, mc_count_o}, 64'h0);
                chk({tn, ".rst_data"}, {mc_data_o, hash_data_o}, 64'h0);
                w_valid = 1'b0; start = 1'b0;
                #2 rst = 1'b0;
                return;
            end

            start = 1'b0;
            if (poke_at >= 0 && wi == poke_at && !poke_used) begin
                poke_used = 1;
                start = 1'b1;
            end
            if (stall_at >= 0 && wi == stall_at + 1 && !stall_used) begin
                stall_used = 1;
                stall_left = 3;
            end
            if (stall_left > 0) begin
                w_valid = 1'b0;
                stall_left--;
            end else begin
                w_valid = (wi < 64);
            end
            w_data = (wi < 64) ? w_tab[wi[5:0]] : 32'h0;
            accept = w_valid && w_ready_o;

            if (hash_valid_o && n_hs == 2 && bp_len > 0 && !bp_used) begin
                bp_used = 1;
                bp_left = bp_len;
            end
            if (bp_left > 0) begin
                hash_ready = 1'b0;
                bp_left--;
                n_bp++;
                if (hash_data_o != 32'h414140de || hash_last_o) bp_hold_ok = 0;
            end else begin
                hash_ready = 1'b1;
            end
            if (hash_valid_o && hash_ready) begin
                if (n_hs < 8) begin
                    got[n_hs] = hash_data_o;
                    last_pat[n_hs] = hash_last_o;
                end
                n_hs++;
                if (hash_last_o) hs7_cyc = cyc;
            end

            step();
            if (accept) wi++;
        end

        start = 1'b0; w_valid = 1'b0;
        chk({tn, ".done_seen"}, (done_cyc >= 0), 1);
        chk({tn, ".done_lat"}, done_cyc - hs7_cyc, 1);
        chk({tn, ".n_words"}, n_hs, 8);
        for (int i = 0; i < 8; i++) chk($sformatf("%s.h%0d", tn, i), got[i], EXP_H[i]);
        chk({tn, ".last_pat"}, last_pat, 8'h80);
        chk({tn, ".mc_rounds"}, {seq_ok, 32'(n_c)}, {1'b1, 32'd64});
        chk({tn, ".read_len"}, n_read, 8 + lat - 1);
        chk({tn, ".cnt7_hold"}, n_c7, lat);
        chk({tn, ".first_hv"}, first_hv, 72 + lat + ((stall_at >= 0) ? 3 : 0));
        chk({tn, ".stall"}, {stall_cnt_ok, 32'(n_stall)}, {1'b1, 32'((stall_at >= 0) ? 3 : 0)});
        chk({tn, ".busy"}, busy_ok, 1);
        if (bp_len > 0) chk({tn, ".bp_hold"}, {bp_hold_ok, 32'(n_bp)}, {1'b1, 32'(bp_len)});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        rst = 1'b1; sel = 1'b0; start = 1'b0; w_valid = 1'b0; hash_ready = 1'b0; w_data = 32'h0;

        for (int t = 0; t < 64; t++) w_tab[t] = 32'h0;
        w_tab[0]  = 32'h61626380;
        w_tab[15] = 32'h00000018;
        for (int t = 16; t < 64; t++)
            w_tab[t] = (rotr(w_tab[t-2], 17) ^ rotr(w_tab[t-2], 19) ^ (w_tab[t-2] >> 10))
                     + w_tab[t-7]
                     + (rotr(w_tab[t-15], 7) ^ rotr(w_tab[t-15], 18) ^ (w_tab[t-15] >> 3))
                     + w_tab[t-16];

        repeat (3) step();
        chk("reset.ctrl", {busy_o, done_o, w_ready_o, hash_valid_o, hash_last_o, mc_fsm_o, mc_count_o}, 64'h0);
        chk("reset.data", {mc_data_o, hash_data_o}, 64'h0);
        #3 rst = 1'b0;
        step();

        bad = 0;
        w_valid = 1'b1; w_data = 32'hdeadbeef;
        for (int i = 0; i < 4; i++) begin
            step();
            if (w_ready_o || mc_fsm_o != 3'b000 || busy_o) bad++;
        end
        w_valid = 1'b0;
        chk("guard.wvalid_idle", bad, 0);

        run_block("abc", -1, 0, -1, -1);
        run_block("stall_b2b", 19, 0, -1, -1);
        step();
        run_block("backpressure", -1, 4, -1, -1);
        step();
        run_block("start_poke", -1, 0, 30, -1);
        step();
        run_block("rst_mid", -1, 0, -1, 40);
        idle_check("rst_mid", 20);
        run_block("restart", -1, 0, -1, -1);
        step();
        sel = 1'b1;
        step();
        run_block("lat3", -1, 0, -1, -1);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/sha256_mc_ctrl.md
# sha256_mc_ctrl

Sequencer for the SHA-256 message-compression datapath `MC`. It accepts the 64 expanded schedule words W[0..63] over a valid/ready stream and drives `MC`'s `FSM_core_in`, `core_count_in` and `data_in` through the 64 compression rounds. It then runs `MC`'s readout phase and captures the eight final hash words H0..H7. The words are streamed out to the downstream result interface. The block sits between the message scheduler and the hash output/host logic.

## Interface
- `DATA_WIDTH`, 32, word width of W, MC data and hash words.
- `RD_LAT`, 1, MC readout latency in cycles (legal 1..4).
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `start` in 1: begin one block compression; honoured only in IDLE.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle pulse after the last hash word handshake.
- `w_data` in DATA_WIDTH: schedule word W[i].
- `w_valid` in 1: `w_data` valid.
- `w_ready` out 1: high only in state COMP.
- `mc_fsm_out` out 3: to MC `FSM_core_in`.
- `mc_count_out` out 7: to MC `core_count_in`.
- `mc_data_out` out DATA_WIDTH: to MC `data_in`.
- `mc_data_in` in DATA_WIDTH: from MC `data_out`.
- `hash_data` out DATA_WIDTH: hash word, H0 first.
- `hash_valid` out 1: `hash_data` valid.
- `hash_ready` in 1: downstream accepts.
- `hash_last` out 1: high with H7.

## Operation
- **MC codes:**
  - 3'b000 = hold. MC keeps its working variables.
  - 3'b011 = compress one round with `data_in` = W[count].
  - 3'b100 = readout. `data_out` = H[count].
- **States:** IDLE, COMP, SETUP, READ, OUT.
- **IDLE:**
  - MC outputs are 000 / 0 / 0.
  - When `start`=1, go to COMP and clear the round counter `rnd`.
- **COMP:**
  - `w_ready`=1. An accept is `w_valid & w_ready`.
  - On accept: register `mc_fsm_out`=011, `mc_count_out`=`rnd`, `mc_data_out`=`w_data`, then increment `rnd`.
  - Without accept: register `mc_fsm_out`=000 and hold count and data. This is a stall.
  - After the accept with `rnd`=63, go to SETUP.
- **SETUP (one cycle):** drive `mc_fsm_out`=100, `mc_count_out`=0.
- **READ:**
  - Drive `mc_fsm_out`=100 and present counts 0..7, one per cycle.
  - Hold count 7 for RD_LAT−1 extra cycles.
  - Word i is captured into a buffer `hbuf[i]` at the edge ending the (RD_LAT)th cycle after count i was first presented.
  - After `hbuf[7]` is captured, go to OUT and drive `mc_fsm_out`=000.
- **OUT:**
  - `hash_valid`=1, `hash_data`=`hbuf[idx]`, `hash_last`=(`idx`==7).
  - `idx` advances on `hash_valid & hash_ready`.
  - The handshake on `idx`=7 returns the block to IDLE and pulses `done` in the next cycle.
- **Guards:**
  - `start` is ignored when state ≠ IDLE.
  - `w_valid` is ignored outside COMP.
- **Widths:**
  - `rnd` is 7 bits and never exceeds 63. There is no wrap, because the state exits at 63.
  - `idx` is 3 bits.

## Timing
- **Reset:** `rst` high immediately (asynchronously) forces:
  - state=IDLE;
  - `rnd`, `idx`, `hbuf` = 0;
  - every output = 0 (`busy`, `done`, `w_ready`, `mc_fsm_out`, `mc_count_out`, `mc_data_out`, `hash_*`).
- **Reset mid-operation:** the block drops to IDLE from any state. No partial hash is emitted and no `done` pulse occurs.
- **Start latency:** `start` sampled at edge e → `w_ready`=1 in the cycle after e.
- **MC drive:** MC sees round i in the cycle after W[i] is accepted, which is a 1-cycle registered delay.
- **Unstalled sequence:**
  - `start` → first `w_ready`: 1 cycle.
  - 64 accept cycles.
  - SETUP: 1 cycle.
  - READ: 8+RD_LAT−1 cycles.
  - First `hash_valid` in the next cycle.
- **OUT backpressure:** `hash_data` and `hash_last` stay stable while `hash_valid`=1 and `hash_ready`=0.
- **Back-to-back blocks:** `done` and `start` in the same cycle → `start` is accepted, because state is already IDLE.

## Test plan
- **Known vector:** real MC, "abc" single block, ideal streams (`w_valid`=1, `hash_ready`=1).
  - Hash words must be ba7816bf, 8f01cfea, 414140de, 5dae2223, b00361a3, 96177a9c, b410ff61, f20015ad.
  - `hash_last` must be high on the 8th word only.
  - `done` must pulse once, one cycle later.
- **Input stall:** deassert `w_valid` for 3 cycles after W[19].
  - `mc_fsm_out` must be 000 for 3 cycles with `mc_count_out` held at 19.
  - The final hash must equal the "abc" result.
- **Output backpressure:** `hash_ready`=0 for 4 cycles at `idx`=2.
  - `hash_data` must hold 414140de.
  - Total words must be 8, with no duplicates or drops.
- **Guards:**
  - `start` pulsed at round 30 → ignored; `rnd` continues.
  - `w_valid` high in IDLE → `w_ready`=0 and MC code stays 000.
- **Reset mid-compression:** assert `rst` at round 40.
  - All outputs must be 0 immediately.
  - A restart with "abc" must produce the correct hash.
- **RD_LAT=3:** use an MC model with 3-cycle readout latency.
  - READ must last 10 cycles with count 7 held for 3 cycles.
  - The captured hash must be correct.
